// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one add/sub datapath
// Grants one requester, latches its operands, computes for one cycle, then holds the response.
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_overflow,
  output logic                     rsp_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              op_sub_q, op_sub_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [WIDTH-1:0]  grant_a;
  logic [WIDTH-1:0]  grant_b;
  logic              grant_sub;

  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH:0]    sum_full;
  logic [WIDTH-1:0]  sum;
  logic              sum_ovf;

  // Two passes give rotating priority: indices at/after rr_ptr first, then the wrapped ones.
  always_comb begin
    grant_found  = 1'b0;
    grant_id     = '0;
    grant_onehot = '0;
    grant_a      = '0;
    grant_b      = '0;
    grant_sub    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && req_valid[j] && (ID_W'(j) >= rr_ptr_q)) begin
        grant_found     = 1'b1;
        grant_id        = ID_W'(j);
        grant_onehot[j] = 1'b1;
        grant_a         = req_a[j*WIDTH +: WIDTH];
        grant_b         = req_b[j*WIDTH +: WIDTH];
        grant_sub       = req_sub[j];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && req_valid[j] && (ID_W'(j) < rr_ptr_q)) begin
        grant_found     = 1'b1;
        grant_id        = ID_W'(j);
        grant_onehot[j] = 1'b1;
        grant_a         = req_a[j*WIDTH +: WIDTH];
        grant_b         = req_b[j*WIDTH +: WIDTH];
        grant_sub       = req_sub[j];
      end
    end
  end

  // Subtraction reuses the adder as A + ~B + 1.
  always_comb begin
    b_eff    = op_sub_q ? ~op_b_q : op_b_q;
    sum_full = {1'b0, op_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub_q};
    sum      = sum_full[WIDTH-1:0];
    if (op_sub_q) begin
      sum_ovf = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) && (sum[WIDTH-1] != op_a_q[WIDTH-1]);
    end else begin
      sum_ovf = sum_full[WIDTH];
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_sub_d       = op_sub_q;
    op_id_d        = op_id_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_id_d       = rsp_id_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_zero_d     = rsp_zero_q;
    req_ready      = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready = grant_onehot;
          op_a_d    = grant_a;
          op_b_d    = grant_b;
          op_sub_d  = grant_sub;
          op_id_d   = grant_id;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_valid_d    = 1'b1;
        rsp_result_d   = sum;
        rsp_overflow_d = sum_ovf;
        rsp_zero_d     = (sum == '0);
        rsp_id_d       = op_id_q;
        rr_ptr_d       = (op_id_q == ID_W'(NUM_REQ-1)) ? '0 : op_id_q + ID_W'(1);
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_sub_q       <= 1'b0;
      op_id_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_id_q       <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_sub_q       <= op_sub_d;
      op_id_q        <= op_id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_id_q       <= rsp_id_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_zero_q     <= rsp_zero_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_zero     = rsp_zero_q;

endmodule
